// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM encodings,
// bit-order selectors and counter sizing.
package serdes_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam int MSB_FIRST = 0;
   localparam int LSB_FIRST = 1;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int clog2_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-WIDTH bit counter that tracks the position inside a serial frame,
// with first/last flags for the frame boundary logic.
module ser_bit_counter
   import serdes_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = clog2_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_is_first,
   output logic          o_is_last
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;
   logic          w_is_last;

   assign w_is_last = (r_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt      = r_cnt;
   assign o_is_first = (r_cnt == '0);
   assign o_is_last  = w_is_last;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word hold buffer so that
// consecutive frames leave back-to-back on ser_out.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   import serdes_pkg::ST_IDLE;
   import serdes_pkg::ST_SHIFT;
   import serdes_pkg::clog2_w;

   localparam int CW         = clog2_w(WIDTH);
   localparam bit SEND_LSB_1ST = (LSB_FIRST == serdes_pkg::LSB_FIRST);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;

   logic             w_xfer;
   logic             w_shifting;
   logic [CW-1:0]    w_cnt;
   logic             w_is_first;
   logic             w_is_last;
   logic [WIDTH-1:0] w_sreg_shifted;

   assign in_ready   = !r_hold_full;
   assign w_xfer     = in_valid && in_ready;
   assign w_shifting = (r_state == ST_SHIFT);

   // The vacated end of the shift register always fills with 0.
   assign w_sreg_shifted = SEND_LSB_1ST ? {1'b0, r_sreg[WIDTH-1:1]}
                                        : {r_sreg[WIDTH-2:0], 1'b0};

   ser_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (!w_shifting),
      .i_en       (w_shifting),
      .o_cnt      (w_cnt),
      .o_is_first (w_is_first),
      .o_is_last  (w_is_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sreg      <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_sreg  <= in_data;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (!w_is_last) begin
                  r_sreg <= w_sreg_shifted;
                  if (w_xfer) begin
                     r_hold      <= in_data;
                     r_hold_full <= 1'b1;
                  end
               end else if (r_hold_full) begin
                  r_sreg      <= r_hold;
                  r_hold_full <= 1'b0;
               end else if (w_xfer) begin
                  // Word offered on the last bit skips the hold buffer.
                  r_sreg <= in_data;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ser_valid   = w_shifting;
   assign ser_out     = ser_valid & (SEND_LSB_1ST ? r_sreg[0] : r_sreg[WIDTH-1]);
   assign frame_start = ser_valid & w_is_first;
   assign busy        = ser_valid | r_hold_full;

   logic w_unused_cnt;
   assign w_unused_cnt = ^w_cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: fixed bit-order vectors, hand-built multi-cycle
// corner sequences and a randomized run against a word-queue reference model.
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data,   l_in_data;
   logic         in_valid,  l_in_valid;
   logic         in_ready,  l_in_ready;
   logic         ser_out,   l_ser_out;
   logic         ser_valid, l_ser_valid;
   logic         frame_start, l_frame_start;
   logic         busy,      l_busy;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ser_out     (ser_out),
      .ser_valid   (ser_valid),
      .frame_start (frame_start),
      .busy        (busy)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .in_data     (l_in_data),
      .in_valid    (l_in_valid),
      .in_ready    (l_in_ready),
      .ser_out     (l_ser_out),
      .ser_valid   (l_ser_valid),
      .frame_start (l_frame_start),
      .busy        (l_busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model for the MSB-first instance: words accepted but not yet
   // fully sent, oldest first, plus the bit position inside the head word.
   logic [W-1:0] wq[$];
   int           pos = 0;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_edge();
      logic take;
      take = in_valid && (wq.size() < 2);
      if (wq.size() > 0) begin
         pos++;
         if (pos == W) begin
            void'(wq.pop_front());
            pos = 0;
         end
      end
      if (take) wq.push_back(in_data);
   endfunction

   task automatic check_model();
      logic         ev;
      logic [W-1:0] head;
      ev   = (wq.size() > 0);
      head = ev ? wq[0] : '0;
      check("m_ser_valid",   ser_valid,   ev);
      check("m_ser_out",     ser_out,     ev & head[W-1-pos]);
      check("m_frame_start", frame_start, ev && (pos == 0));
      check("m_busy",        busy,        ev);
      check("m_in_ready",    in_ready,    wq.size() < 2);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      string        name;
      logic         lsb;
      logic [W-1:0] data;
      logic [W-1:0] exp_bits;   // transmission order, leftmost bit sent first
   } vec_t;

   vec_t vecs[6];

   int           n_valid, n_fs, n_acc, n_blocked;
   logic         took;
   logic [W-1:0] c3_bits;

   initial begin
      vecs[0] = '{"msb_a5", 1'b0, 8'hA5, 8'b1010_0101};
      vecs[1] = '{"lsb_01", 1'b1, 8'h01, 8'b1000_0000};
      vecs[2] = '{"msb_3c", 1'b0, 8'h3C, 8'b0011_1100};
      vecs[3] = '{"lsb_80", 1'b1, 8'h80, 8'b0000_0001};
      vecs[4] = '{"lsb_c8", 1'b1, 8'hC8, 8'b0001_0011};
      vecs[5] = '{"msb_01", 1'b0, 8'h01, 8'b0000_0001};

      rst = 1'b1;
      in_valid = 1'b0;  in_data = '0;
      l_in_valid = 1'b0; l_in_data = '0;
      #1;
      check("rst_ser_out",     ser_out,     1'b0);
      check("rst_ser_valid",   ser_valid,   1'b0);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_busy",        busy,        1'b0);
      check("rst_in_ready",    in_ready,    1'b1);
      check("rst_lsb_valid",   l_ser_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_model();

      // Single-word frames in both bit orders.
      foreach (vecs[k]) begin
         if (vecs[k].lsb) begin
            l_in_data = vecs[k].data; l_in_valid = 1'b1;
         end else begin
            in_data = vecs[k].data; in_valid = 1'b1;
         end
         step();
         in_valid = 1'b0; l_in_valid = 1'b0;
         for (int i = 0; i < W; i++) begin
            check({vecs[k].name, "_valid"}, vecs[k].lsb ? l_ser_valid : ser_valid, 1'b1);
            check({vecs[k].name, "_bit"},   vecs[k].lsb ? l_ser_out : ser_out, vecs[k].exp_bits[W-1-i]);
            check({vecs[k].name, "_fs"},    vecs[k].lsb ? l_frame_start : frame_start, i == 0);
            step();
         end
         check({vecs[k].name, "_idle"}, vecs[k].lsb ? l_ser_valid : ser_valid, 1'b0);
         check({vecs[k].name, "_ready"}, vecs[k].lsb ? l_in_ready : in_ready, 1'b1);
      end

      // Back-to-back frames through the hold buffer.
      in_data = 8'hF0; in_valid = 1'b1;
      step();
      check("b2b_fs0", frame_start, 1'b1);
      check("b2b_ready0", in_ready, 1'b1);
      n_valid = 1;
      in_data = 8'h0F;
      step();
      in_valid = 1'b0;
      check("b2b_ready_held", in_ready, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         if (c > 1) step();
         if (ser_valid) n_valid++;
         if (c == 7) check("b2b_ready_last", in_ready, 1'b0);
         if (c == 8) begin
            check("b2b_fs8", frame_start, 1'b1);
            check("b2b_ready_drained", in_ready, 1'b1);
         end
      end
      check_int("b2b_valid_cycles", n_valid, 16);
      repeat (2) step();

      // A word offered exactly on the last bit bypasses the hold buffer.
      in_data = 8'hFF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (W - 1) step();
      check("byp_last_valid", ser_valid, 1'b1);
      in_data = 8'hC3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      c3_bits = 8'b1100_0011;
      for (int i = 0; i < W; i++) begin
         check("byp_valid", ser_valid, 1'b1);
         check("byp_bit", ser_out, c3_bits[W-1-i]);
         check("byp_fs", frame_start, i == 0);
         step();
      end
      check("byp_idle", ser_valid, 1'b0);
      step();

      // Asynchronous reset mid-frame with a word in the hold buffer.
      in_data = 8'hAA; in_valid = 1'b1;
      step();
      in_data = 8'h55;
      step();
      in_valid = 1'b0;
      step();
      check("rmf_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rmf_ser_out",     ser_out,     1'b0);
      check("rmf_ser_valid",   ser_valid,   1'b0);
      check("rmf_frame_start", frame_start, 1'b0);
      check("rmf_busy",        busy,        1'b0);
      check("rmf_in_ready",    in_ready,    1'b1);
      wq.delete();
      pos = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_model();
      repeat (10) step();
      check("rmf_no_resume", ser_valid, 1'b0);

      // Backpressure: a word held on in_valid while the hold buffer is full.
      in_data = 8'h12; in_valid = 1'b1;
      step();
      in_data = 8'h34;
      step();
      in_data = 8'h77;
      n_acc = 0; n_blocked = 0; n_fs = 0;
      for (int c = 0; c < 20; c++) begin
         took = in_valid && in_ready;
         if (in_valid && !in_ready) n_blocked++;
         if (took) n_acc++;
         step();
         if (took) in_valid = 1'b0;
         if (frame_start) n_fs++;
      end
      check_int("bp_blocked_cycles", n_blocked, 7);
      check_int("bp_accepts", n_acc, 1);
      check_int("bp_frames", n_fs, 2);
      repeat (4) step();
      check("bp_idle", ser_valid, 1'b0);

      // Randomized traffic with bursts and quiet stretches.
      for (int c = 0; c < 3000; c++) begin
         if ((c % 250) > 200) in_valid = 1'b0;
         else                 in_valid = ($urandom_range(0, 3) != 0);
         in_data = W'($urandom);
         step();
      end
      in_valid = 1'b0;
      repeat (3 * W) step();
      check("rand_drained", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
